hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//   Per-register write-pending scoreboard feeding hazard_in of the decode stage.
//   - Marks a destination pending when decode issues a write-back instruction.
//   - Clears the mark when the write-back stage commits that register.
//   - Flags a RAW hazard when a source of the current decode instruction is still pending.
//   - Sits between the decode stage (issue side) and the write-back stage (retire side).
// PARAMETERS
//   NUM_REGS  16  architectural registers tracked; must equal 2**REG_W
//   REG_W     4   register index width
//   CNT_W     2   per-register pending counter width; max in-flight writes per reg = 2**CNT_W-1
//   PERF_W    16  stall performance counter width
// PORTS
//   clk            in   1         rising-edge clock
//   rst            in   1         asynchronous, active-low reset
//   issue_valid    in   1         decode instruction attempts to leave ID this cycle (condition passed)
//   issue_wb_en    in   1         that instruction writes a register
//   issue_dest     in   REG_W     its destination register
//   src1           in   REG_W     first source (Rn)
//   src2           in   REG_W     second source (Rm, or Rd for stores)
//   two_src        in   1         src2 is a real operand
//   retire_valid   in   1         write-back stage commits a register this cycle (wb_enable)
//   retire_dest    in   REG_W     register committed
//   hazard_out     out  1         stall decode; combinational
//   pending_mask   out  NUM_REGS  bit r = counter[r] != 0; registered view
//   err_out        out  1         sticky: retire seen for a register with counter 0
//   stall_cnt_out  out  PERF_W    cycles with issue_valid & hazard_out; saturating
// BEHAVIOUR
//   Reset, asynchronous while rst==0:
//     - all counters 0, pending_mask 0, err_out 0, stall_cnt_out 0.
//     - hazard_out is therefore 0 during reset.
//   hazard_out (combinational from current counters and inputs):
//     - (cnt[src1]!=0) | (two_src & cnt[src2]!=0) | (issue_wb_en & cnt[issue_dest]==MAX).
//     - The MAX term is a structural stall: counter saturated, so no new write may issue.
//     - src2 is ignored when two_src==0.
//   issue_accept = issue_valid & issue_wb_en & ~hazard_out.
//     - When hazard_out=1 the issue is not recorded; decode re-presents it next cycle.
//   retire_ok = retire_valid & (cnt[retire_dest]!=0).
//   Counter update at posedge clk, per register r:
//     - issue_accept to r only  -> cnt+1.
//     - retire_ok to r only     -> cnt-1.
//     - both to r, same cycle   -> cnt unchanged.
//     - neither                 -> hold.
//     - Counters never wrap; the MAX stall and the retire_ok guard prevent it.
//   retire_valid with cnt[retire_dest]==0: counter held at 0, err_out set to 1 until reset.
//   pending_mask: registered, reflects counters after the update edge (1-cycle latency from issue/retire).
//   stall_cnt_out: increments each cycle issue_valid & hazard_out; holds at 2**PERF_W-1.
//   Latency:
//     - Issue to pending visible: 1 clk.
//     - Retire to pending cleared: 1 clk, unless WB_BYPASS_EN is defined.
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     - A source whose cnt==1 is treated as not pending when retire_valid & retire_dest==src the same cycle.
//     - The register file write-before-read covers that case, saving one stall cycle per dependency.
//   WB_BYPASS_EN undefined:
//     - Any cnt!=0 stalls, regardless of a same-cycle retire.
//   The macro affects hazard_out only; counter update rules are identical in both builds.
// TESTING
//   1. Reset: rst=0 mid-run with cnt[3]=2.
//      -> All counters, pending_mask, err_out and stall_cnt_out read 0 asynchronously; hazard_out=0.
//   2. RAW: issue wb to R2.
//      -> Next cycle src1=2 gives hazard_out=1.
//      -> Retire R2 at cycle 3.
//      -> Without bypass, hazard_out=0 at cycle 4; with WB_BYPASS_EN, hazard_out=0 at cycle 3.
//   3. Saturation with CNT_W=2: three issues to R5, no retires.
//      -> cnt[5]=3; a 4th issue to R5 gives hazard_out=1 and cnt stays 3.
//   4. Same-cycle issue and retire, both R7, cnt[7]=1.
//      -> cnt[7] stays 1 and pending_mask[7]=1.
//   5. two_src gating: cnt[9]=1, src1=0, src2=9.
//      -> two_src=0 gives hazard_out=0; two_src=1 gives hazard_out=1.
//   6. Spurious retire of R4 with cnt[4]=0.
//      -> err_out=1 next cycle, cnt[4]=0, err_out sticky until rst.
//   7. Stall counter: hold issue_valid=1 on a hazard for 5 cycles.
//      -> stall_cnt_out=5.
//      -> Preload near max to check saturation at 0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register write-pending scoreboard driving the decode-stage RAW stall.
// Define WB_BYPASS_EN to let a same-cycle final retire unblock its reader.
module hazard_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 4,
  parameter int CNT_W    = 2,
  parameter int PERF_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [REG_W-1:0]    issue_dest,
  input  logic [REG_W-1:0]    src1,
  input  logic [REG_W-1:0]    src2,
  input  logic                two_src,
  input  logic                retire_valid,
  input  logic [REG_W-1:0]    retire_dest,
  output logic                hazard_out,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                err_out,
  output logic [PERF_W-1:0]   stall_cnt_out
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic                err_q, err_d;
  logic [PERF_W-1:0]   stall_q, stall_d;
  logic                src1_busy, src2_busy;
  logic                sat, issue_acc, retire_ok;

`ifdef WB_BYPASS_EN
  // Last outstanding write lands this cycle; regfile write-before-read covers it
  logic src1_byp, src2_byp;
  assign src1_byp  = retire_valid & (retire_dest == src1)
                   & (cnt_q[src1] == CONE);
  assign src2_byp  = retire_valid & (retire_dest == src2)
                   & (cnt_q[src2] == CONE);
  assign src1_busy = (cnt_q[src1] != '0) & ~src1_byp;
  assign src2_busy = (cnt_q[src2] != '0) & ~src2_byp;
`else
  assign src1_busy = cnt_q[src1] != '0;
  assign src2_busy = cnt_q[src2] != '0;
`endif

  assign sat        = issue_wb_en & (cnt_q[issue_dest] == CMAX);
  assign hazard_out = src1_busy | (two_src & src2_busy) | sat;
  assign issue_acc  = issue_valid & issue_wb_en & ~hazard_out;
  assign retire_ok  = retire_valid & (cnt_q[retire_dest] != '0);

  always_comb begin
    mask_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      unique case ({issue_acc & (issue_dest == REG_W'(r)),
                    retire_ok & (retire_dest == REG_W'(r))})
        2'b10:   cnt_d[r] = cnt_q[r] + CONE;
        2'b01:   cnt_d[r] = cnt_q[r] - CONE;
        default: cnt_d[r] = cnt_q[r];
      endcase
      mask_d[r] = cnt_d[r] != '0;
    end
  end

  always_comb begin
    err_d   = err_q | (retire_valid & ~retire_ok);
    stall_d = stall_q;
    if (issue_valid & hazard_out & (stall_q != '1))
      stall_d = stall_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign pending_mask  = mask_q;
  assign err_out       = err_q;
  assign stall_cnt_out = stall_q;

endmodule
